// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mole_pkg
// Description : Shared types and constants for the mole display path:
//               sprite bank codes, sequencer state encoding and the hole
//               position table used by the game FSM and display mux.
// Revision    : 1.0 - initial release
// ============================================================================
package mole_pkg;

    typedef enum logic [1:0] {
        SPR_NONE   = 2'd0,
        SPR_NORMAL = 2'd1,
        SPR_HAPPY  = 2'd2,
        SPR_DEAD   = 2'd3
    } sprite_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ASCEND     = 3'd1,
        ST_UP         = 3'd2,
        ST_DESC_HAPPY = 3'd3,
        ST_DESC_DEAD  = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    // Screen position of each of the eight holes (3 x top row, 2 middle, 3 bottom)
    localparam logic [10:0] c_hole_x [8] = '{
        11'd65, 11'd406, 11'd747, 11'd65, 11'd747, 11'd65, 11'd406, 11'd747
    };
    localparam logic [9:0] c_hole_yp [8] = '{
        10'd0, 10'd0, 10'd0, 10'd256, 10'd256, 10'd512, 10'd512, 10'd512
    };

    // Sprite bank shown while the sequencer sits in a given state
    function automatic sprite_t sprite_of(input state_t s);
        case (s)
            ST_ASCEND, ST_UP: return SPR_NORMAL;
            ST_DESC_HAPPY:    return SPR_HAPPY;
            ST_DESC_DEAD:     return SPR_DEAD;
            default:          return SPR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_tick_gen
// Description : Free-running divider producing a registered one-cycle tick
//               every DIV clocks (high every cycle when DIV = 1).
// Revision    : 1.0 - initial release
// ============================================================================
module step_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int              c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

    logic [c_cw-1:0] r_cnt;
    logic            r_tick;

    // Count 0..DIV-1 and flag the wrap one cycle later as the tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == c_last);
            r_cnt  <= (r_cnt == c_last) ? '0 : r_cnt + c_cw'(1);
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/mole_popup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mole_popup_sequencer
// Description : Runs one mole through pop-up, hold and retreat. Resolves the
//               requested hole to screen coordinates, steps the sprite top
//               line once per step tick, selects the sprite bank and reports
//               the outcome with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_popup_sequencer
    import mole_pkg::*;
#(
    parameter int STEP_DIV   = 33750,
    parameter int HEIGHT     = 256,
    parameter int HOLD_TICKS = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  req_loc,
    input  logic        whack,
    output logic [10:0] mole_x,
    output logic [9:0]  mole_y,
    output logic [9:0]  mole_yp,
    output logic [1:0]  sprite,
    output logic        busy,
    output logic        done,
    output logic        whacked
);

    localparam int              c_hw        = ($clog2(HOLD_TICKS) > 10) ? $clog2(HOLD_TICKS) : 10;
    localparam logic [8:0]      c_height    = 9'(HEIGHT);
    localparam logic [8:0]      c_height_m1 = 9'(HEIGHT - 1);
    localparam logic [c_hw-1:0] c_hold_last = c_hw'(HOLD_TICKS - 1);

    logic w_tick;

    state_t          r_state, w_state_next;
    logic [8:0]      r_off, w_off_next;
    logic [c_hw-1:0] r_hold, w_hold_next;
    logic [10:0]     r_mole_x, w_x_next;
    logic [9:0]      r_mole_yp, w_yp_next;
    logic            r_whacked, w_whacked_next;
    logic [9:0]      r_mole_y;
    sprite_t         r_sprite;
    logic            r_busy;
    logic            r_done;

    step_tick_gen #(.DIV(STEP_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Next-state and datapath update; whack outranks a same-cycle tick
    always_comb begin
        w_state_next   = r_state;
        w_off_next     = r_off;
        w_hold_next    = r_hold;
        w_x_next       = r_mole_x;
        w_yp_next      = r_mole_yp;
        w_whacked_next = r_whacked;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_x_next       = c_hole_x[req_loc];
                    w_yp_next      = c_hole_yp[req_loc];
                    w_off_next     = c_height;
                    w_whacked_next = 1'b0;
                    w_state_next   = ST_ASCEND;
                end
            end
            ST_ASCEND: begin
                if (whack) begin
                    w_whacked_next = 1'b1;
                    w_state_next   = ST_DESC_DEAD;
                end else if (w_tick) begin
                    w_off_next = r_off - 9'd1;
                    if (r_off == 9'd1) begin
                        w_hold_next  = '0;
                        w_state_next = ST_UP;
                    end
                end
            end
            ST_UP: begin
                if (whack) begin
                    w_whacked_next = 1'b1;
                    w_state_next   = ST_DESC_DEAD;
                end else if (w_tick) begin
                    if (r_hold == c_hold_last) begin
                        w_state_next = ST_DESC_HAPPY;
                    end else begin
                        w_hold_next = r_hold + c_hw'(1);
                    end
                end
            end
            ST_DESC_HAPPY, ST_DESC_DEAD: begin
                // A whack on the very first ascend cycle leaves the mole hidden
                if (r_off == c_height) begin
                    w_state_next = ST_DONE;
                end else if (w_tick) begin
                    if (r_off == c_height_m1) begin
                        w_off_next   = c_height;
                        w_state_next = ST_DONE;
                    end else begin
                        w_off_next = r_off + 9'd1;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_off     <= c_height;
            r_hold    <= '0;
            r_mole_x  <= c_hole_x[0];
            r_mole_yp <= c_hole_yp[0];
            r_whacked <= 1'b0;
            r_mole_y  <= c_hole_yp[0] + {1'b0, c_height};
            r_sprite  <= SPR_NONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_off     <= w_off_next;
            r_hold    <= w_hold_next;
            r_mole_x  <= w_x_next;
            r_mole_yp <= w_yp_next;
            r_whacked <= w_whacked_next;
            r_mole_y  <= w_yp_next + {1'b0, w_off_next};
            r_sprite  <= sprite_of(w_state_next);
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= (w_state_next == ST_DONE);
        end
    end

    assign mole_x  = r_mole_x;
    assign mole_y  = r_mole_y;
    assign mole_yp = r_mole_yp;
    assign sprite  = r_sprite;
    assign busy    = r_busy;
    assign done    = r_done;
    assign whacked = r_whacked;

endmodule
`default_nettype wire

// File: tb/tb_mole_popup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mole_popup_sequencer
// Description : Self-checking bench: directed scenarios plus random traffic,
//               every cycle compared against a behavioural mole model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_popup_sequencer;

    localparam int STEP_DIV   = 4;
    localparam int HEIGHT     = 8;
    localparam int HOLD_TICKS = 3;

    localparam int P_IDLE = 0, P_RISE = 1, P_UP = 2, P_HAPPY = 3, P_DEAD = 4, P_DONE = 5;

    logic        clk = 1'b0;
    logic        reset, req, whack;
    logic [2:0]  req_loc;
    logic [10:0] mole_x;
    logic [9:0]  mole_y, mole_yp;
    logic [1:0]  sprite;
    logic        busy, done, whacked;

    mole_popup_sequencer #(
        .STEP_DIV(STEP_DIV), .HEIGHT(HEIGHT), .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_loc(req_loc), .whack(whack),
        .mole_x(mole_x), .mole_y(mole_y), .mole_yp(mole_yp), .sprite(sprite),
        .busy(busy), .done(done), .whacked(whacked)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Hole table as the game sees it
    int tx[8]  = '{65, 406, 747, 65, 747, 65, 406, 747};
    int typ[8] = '{0, 0, 0, 256, 256, 512, 512, 512};

    // Behavioural model: where the mole is and what it looks like
    int m_phase, m_off, m_hold, m_x, m_yp, m_wh, m_cyc;
    bit m_valid = 0;
    bit m_t;
    int m_done_cnt = 0;
    int d_done_cnt = 0;

    function automatic int exp_sprite(int ph);
        case (ph)
            P_RISE, P_UP: return 1;
            P_HAPPY:      return 2;
            P_DEAD:       return 3;
            default:      return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1; m_cyc = 0;
            m_phase = P_IDLE; m_off = HEIGHT; m_hold = 0;
            m_x = tx[0]; m_yp = typ[0]; m_wh = 0;
        end else if (m_valid) begin
            // the step tick arrives every STEP_DIV cycles counted from reset
            m_t = (m_cyc > 0) && (m_cyc % STEP_DIV == 0);
            m_cyc++;
            case (m_phase)
                P_IDLE: if (req) begin
                    m_x = tx[req_loc]; m_yp = typ[req_loc];
                    m_off = HEIGHT; m_wh = 0; m_phase = P_RISE;
                end
                P_RISE, P_UP: begin
                    if (whack) begin
                        m_wh = 1; m_phase = P_DEAD;
                    end else if (m_t && m_phase == P_RISE) begin
                        m_off--;
                        if (m_off == 0) begin m_hold = 0; m_phase = P_UP; end
                    end else if (m_t) begin
                        if (m_hold == HOLD_TICKS - 1) m_phase = P_HAPPY;
                        else m_hold++;
                    end
                end
                P_HAPPY, P_DEAD: begin
                    if (m_off == HEIGHT) m_phase = P_DONE;
                    else if (m_t) begin
                        m_off++;
                        if (m_off == HEIGHT) m_phase = P_DONE;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("mole_x",  mole_x,  m_x);
            check("mole_yp", mole_yp, m_yp);
            check("mole_y",  mole_y,  m_yp + m_off);
            check("sprite",  sprite,  exp_sprite(m_phase));
            check("busy",    busy,    m_phase != P_IDLE);
            check("done",    done,    m_phase == P_DONE);
            check("whacked", whacked, m_wh);
            if (m_phase == P_DONE) m_done_cnt++;
            if (done === 1'b1) d_done_cnt++;
        end
    end

    int k;
    int cnt;

    task automatic start(input int loc);
        req = 1'b1; req_loc = 3'(loc);
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic hit();
        whack = 1'b1;
        @(negedge clk);
        whack = 1'b0;
    endtask

    task automatic wait_idle();
        k = 0;
        while (busy !== 1'b0 && k < 300) begin @(negedge clk); k++; end
        check("wait_idle", busy, 0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; whack = 1'b0; req_loc = 3'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_x", mole_x, 65);   check("rst_y", mole_y, 8);
        check("rst_yp", mole_yp, 0);  check("rst_sprite", sprite, 0);
        check("rst_busy", busy, 0);   check("rst_done", done, 0);
        check("rst_whacked", whacked, 0);

        // 1: undisturbed sequence at hole 5
        start(5);
        check("s1_x", mole_x, 65);    check("s1_yp", mole_yp, 512);
        check("s1_y", mole_y, 520);   check("s1_sprite", sprite, 1);
        k = 0;
        while (!(mole_y === 10'd512) && k < 200) begin @(negedge clk); k++; end
        check("s1_reach_up", mole_y, 512);
        check("s1_model_up", m_phase, P_UP);
        k = 0;
        while (!(sprite === 2'd2) && k < 200) begin @(negedge clk); k++; end
        check("s1_happy", sprite, 2);
        check("s1_happy_y", mole_y, 512);
        k = 0;
        while (!(done === 1'b1) && k < 200) begin @(negedge clk); k++; end
        check("s1_done", done, 1);    check("s1_whacked", whacked, 0);
        check("s1_done_y", mole_y, 520);
        @(negedge clk);
        check("s1_idle_busy", busy, 0); check("s1_idle_done", done, 0);

        // 2: whack mid-ascent at hole 2
        start(2);
        check("s2_x", mole_x, 747);
        k = 0;
        while (!(mole_y === 10'd4) && k < 200) begin @(negedge clk); k++; end
        check("s2_reach_y4", mole_y, 4);
        hit();
        check("s2_dead", sprite, 3);  check("s2_y_kept", mole_y, 4);
        k = 0;
        while (!(done === 1'b1) && k < 200) begin @(negedge clk); k++; end
        check("s2_done", done, 1);    check("s2_whacked", whacked, 1);
        check("s2_done_y", mole_y, 8);
        wait_idle();

        // 3: whack on the same edge as the final hold tick
        start(0);
        k = 0;
        while (!(m_phase == P_UP && m_hold == HOLD_TICKS - 1 && m_cyc > 0 &&
                 m_cyc % STEP_DIV == 0) && k < 200) begin
            @(negedge clk); k++;
        end
        check("s3_reach_last_hold", (m_phase == P_UP) ? 1 : 0, 1);
        hit();
        check("s3_dead", sprite, 3);  check("s3_whacked", whacked, 1);
        check("s3_y", mole_y, 0);
        wait_idle();

        // 4: request while busy is dropped; whack while retreating is ignored
        start(1);
        check("s4_x", mole_x, 406);
        start(7);
        check("s4_x_kept", mole_x, 406); check("s4_yp_kept", mole_yp, 0);
        k = 0;
        while (!(sprite === 2'd2) && k < 200) begin @(negedge clk); k++; end
        check("s4_happy", sprite, 2);
        hit();
        check("s4_whack_ignored", sprite, 2); check("s4_not_whacked", whacked, 0);
        cnt = 0; k = 0;
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk); k++;
            if (done === 1'b1) cnt++;
        end
        check("s4_single_done", cnt, 1);

        // 5: reset while fully up
        start(6);
        k = 0;
        while (!(mole_y === 10'd512 && sprite === 2'd1) && k < 200) begin @(negedge clk); k++; end
        check("s5_reach_up", mole_y, 512);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("s5_x", mole_x, 65);    check("s5_y", mole_y, 8);
        check("s5_yp", mole_yp, 0);   check("s5_sprite", sprite, 0);
        check("s5_busy", busy, 0);    check("s5_done", done, 0);
        check("s5_whacked", whacked, 0);
        start(3);
        check("s5_restart_y", mole_y, 264);
        k = 0;
        while (!(done === 1'b1) && k < 200) begin @(negedge clk); k++; end
        check("s5_done", done, 1);    check("s5_done_y", mole_y, 264);
        wait_idle();

        // 6: hole table sweep; an immediate whack retires the hidden mole at once
        for (int i = 0; i < 8; i++) begin
            start(i);
            check("s6_x", mole_x, tx[i]); check("s6_yp", mole_yp, typ[i]);
            hit();
            check("s6_dead", sprite, 3);
            @(negedge clk);
            check("s6_done", done, 1);
            @(negedge clk);
            check("s6_idle", busy, 0);
        end

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            req     = ($urandom_range(0, 15) == 0);
            req_loc = 3'($urandom_range(0, 7));
            whack   = ($urandom_range(0, 39) == 0);
            reset   = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        req = 1'b0; whack = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("done_count", d_done_cnt, m_done_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mole_popup_sequencer.md
# mole_popup_sequencer

Sequences one mole sprite through pop-up, hold and retreat for the mole display path. It accepts a one-cycle request from the game FSM with a hole index and resolves the hole to screen coordinates. It steps the sprite's top edge one line per step tick, picks which sprite bank (normal/happy/dead) is shown, and reports completion and outcome with a one-cycle `done` pulse. It sits between the game-state FSM and the mole sprite ROM blocks.

## Interface
- `STEP_DIV`, 33750: clk cycles per animation step tick; must be ≥ 1.
- `HEIGHT`, 256: sprite height in lines, 1..256.
- `HOLD_TICKS`, 512: step ticks the mole stays fully up before escaping; must be ≥ 1.
- `clk`  in  1  pixel-domain clock. One clock only.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  one-cycle pop-up request. Accepted only in IDLE.
- `req_loc`  in  3  hole index 0..7, sampled with an accepted `req`.
- `whack`  in  1  one-cycle hit indication. Honoured only in ASCEND/UP.
- `mole_x`  out  11  sprite left edge.
- `mole_y`  out  10  current sprite top line (`mole_yp + off`).
- `mole_yp`  out  10  fixed hole top line, used as the clip border.
- `sprite`  out  2  0 = none, 1 = normal, 2 = happy, 3 = dead.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a sequence.
- `whacked`  out  1  outcome. Valid with `done`; held until the next accept.

## Operation
- States: IDLE, ASCEND, UP, DESC_HAPPY, DESC_DEAD, DONE.
- Internal registers:
  - `off` is 9 bits, range 0..HEIGHT. 0 means fully up; HEIGHT means hidden.
  - `hold` is 10 bits or wider.
- Hole table: x = {65, 406, 747, 65, 747, 65, 406, 747}; yp = {0, 0, 0, 256, 256, 512, 512, 512}.
- IDLE + `req`:
  - latch `mole_x` and `mole_yp` from the table entry for `req_loc`;
  - `off` ← HEIGHT, `whacked` ← 0;
  - go to ASCEND.
- ASCEND, on tick:
  - if `off` == 1: `off` ← 0, `hold` ← 0, go to UP;
  - otherwise `off` ← `off` − 1.
- UP, on tick:
  - if `hold` == HOLD_TICKS−1, go to DESC_HAPPY;
  - otherwise `hold` ← `hold` + 1.
- `whack` in ASCEND or UP: go to DESC_DEAD on the next edge, keeping the current `off`, and set `whacked` ← 1.
  - `whack` has priority over a tick-driven transition in the same cycle.
- DESC_HAPPY / DESC_DEAD, on tick:
  - if `off` == HEIGHT−1: `off` ← HEIGHT, go to DONE;
  - otherwise `off` ← `off` + 1.
  - `whack` is ignored in both states.
  - If `off` already equals HEIGHT, go to DONE on the next edge.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `sprite` by state: IDLE 0, DONE 0, ASCEND/UP 1, DESC_HAPPY 2, DESC_DEAD 3.
- `req` while `busy` is ignored; it is not queued.
- `req` and `whack` together in IDLE: the request is accepted and `whack` is ignored.
- Arithmetic: `mole_y` = `mole_yp` + zero-extended `off`, computed in 10 bits. The maximum value is 512 + 256 = 768, so it never wraps.

## Timing
- Reset values:
  - state IDLE;
  - `mole_x` 65, `mole_y` 256, `mole_yp` 0 (hole 0, hidden);
  - `sprite` 0, `busy` 0, `done` 0, `whacked` 0;
  - tick counter 0, `off` HEIGHT, `hold` 0.
- Reset mid-sequence returns to this state on the next edge. No `done` pulse is produced.
- All outputs are registered.
- Request to first output change:
  - `req` sampled at edge n;
  - `busy` = 1, `sprite` = 1, `mole_y` = `mole_yp` + HEIGHT visible after edge n.
- Step tick generation:
  - tick counter runs 0..STEP_DIV−1, free-running from reset and never re-phased by `req`;
  - tick is the registered pulse when the count is STEP_DIV−1;
  - with STEP_DIV = 1 the tick is high every cycle.
- Full undisturbed sequence: HEIGHT ticks to ascend, HOLD_TICKS ticks up, HEIGHT ticks to descend, plus a 1-cycle DONE and up to one tick of phase slip per state.
- `whack` latency: `sprite` = 3 one cycle after `whack` is sampled.

## Structure
- Shared package `mole_pkg`:
  - sprite codes (SPR_NONE/NORMAL/HAPPY/DEAD);
  - the 8-entry hole x/yp constant arrays;
  - the state enum.
  - The game FSM and the display mux use the same package.
- One sub-module, `step_tick_gen #(DIV)`: takes `clk` and `reset`, outputs the `tick` pulse.
- The FSM, the `off`/`hold` datapath and the location lookup stay in the top module.

## Test plan
All scenarios use STEP_DIV = 4, HEIGHT = 8, HOLD_TICKS = 3.

1. Reset, then `req` with `req_loc` = 5.
   - Immediately: `mole_x` = 65, `mole_yp` = 512, `mole_y` = 520, `sprite` = 1.
   - After 8 ticks: `mole_y` = 512 and state is UP.
   - After 3 more ticks: `sprite` = 2.
   - After 8 more ticks: `mole_y` = 520, then `done` = 1 for one cycle with `whacked` = 0, then `busy` = 0.
2. `req` with `req_loc` = 2, then `whack` when `mole_y` = 4.
   - Next cycle: `sprite` = 3 and `mole_y` = 4.
   - `mole_y` climbs back to 8, then `done` with `whacked` = 1.
3. `whack` in the same cycle as the final UP hold tick: DESC_DEAD is entered (not DESC_HAPPY) and `whacked` = 1.
4. Second `req` (`req_loc` = 7) while `busy`: `mole_x` and `mole_yp` are unchanged and `done` is counted once; a `whack` during DESC_HAPPY leaves `sprite` = 2.
5. Reset asserted during UP: next cycle all outputs equal their reset values, no `done` is seen, and a following `req` sequences normally.
6. Sweep `req_loc` 0..7: `mole_x`/`mole_yp` match the hole table for every index.
